// File: rtl/nnrv_alu_arb_if.sv
// Requester, shared-ALU and response signal bundle for nnrv_alu_arb.
// slave = arbiter side, master = requester/ALU environment side.
interface nnrv_alu_arb_if #(
  parameter int XLEN = 32
);
  logic            i_req0_valid;
  logic            o_req0_ready;
  logic [XLEN-1:0] i_req0_op1;
  logic [XLEN-1:0] i_req0_op2;
  logic [3:0]      i_req0_exec_type;
  logic [4:0]      i_req0_rd;
  logic            i_req1_valid;
  logic            o_req1_ready;
  logic [XLEN-1:0] i_req1_op1;
  logic [XLEN-1:0] i_req1_op2;
  logic [3:0]      i_req1_exec_type;
  logic [4:0]      i_req1_rd;
  logic [XLEN-1:0] o_alu_op1;
  logic [XLEN-1:0] o_alu_op2;
  logic [3:0]      o_alu_exec_type;
  logic [4:0]      o_alu_rd;
  logic            i_alu_rd_en;
  logic [4:0]      i_alu_rd;
  logic [XLEN-1:0] i_alu_rd_reg;
  logic            o_rsp0_valid;
  logic            i_rsp0_ready;
  logic            o_rsp0_rd_en;
  logic [4:0]      o_rsp0_rd;
  logic [XLEN-1:0] o_rsp0_rd_reg;
  logic            o_rsp1_valid;
  logic            i_rsp1_ready;
  logic            o_rsp1_rd_en;
  logic [4:0]      o_rsp1_rd;
  logic [XLEN-1:0] o_rsp1_rd_reg;

  modport slave (
    input  i_req0_valid, i_req0_op1, i_req0_op2, i_req0_exec_type, i_req0_rd,
    input  i_req1_valid, i_req1_op1, i_req1_op2, i_req1_exec_type, i_req1_rd,
    output o_req0_ready, o_req1_ready,
    output o_alu_op1, o_alu_op2, o_alu_exec_type, o_alu_rd,
    input  i_alu_rd_en, i_alu_rd, i_alu_rd_reg,
    input  i_rsp0_ready, i_rsp1_ready,
    output o_rsp0_valid, o_rsp0_rd_en, o_rsp0_rd, o_rsp0_rd_reg,
    output o_rsp1_valid, o_rsp1_rd_en, o_rsp1_rd, o_rsp1_rd_reg
  );

  modport master (
    output i_req0_valid, i_req0_op1, i_req0_op2, i_req0_exec_type, i_req0_rd,
    output i_req1_valid, i_req1_op1, i_req1_op2, i_req1_exec_type, i_req1_rd,
    input  o_req0_ready, o_req1_ready,
    input  o_alu_op1, o_alu_op2, o_alu_exec_type, o_alu_rd,
    output i_alu_rd_en, i_alu_rd, i_alu_rd_reg,
    output i_rsp0_ready, i_rsp1_ready,
    input  o_rsp0_valid, o_rsp0_rd_en, o_rsp0_rd, o_rsp0_rd_reg,
    input  o_rsp1_valid, o_rsp1_rd_en, o_rsp1_rd, o_rsp1_rd_reg
  );
endinterface

// File: rtl/nnrv_alu_arb.sv
// Two-requester arbiter in front of a shared registered ALU, one outstanding op per requester.
// Define NNRV_ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins); default is round-robin.
module nnrv_alu_arb #(
  parameter int XLEN = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  nnrv_alu_arb_if.slave bus
);
  logic [1:0]      busy_r;
  logic [1:0]      elig_s;
  logic [1:0]      ready_s;
  logic [1:0]      acc_s;
  logic [1:0]      rsp_ready_s;
  logic [1:0]      rsp_hs_s;
  logic [1:0]      cap_s;
  logic            tag1_valid_r;
  logic            tag1_owner_r;
  logic            tag2_valid_r;
  logic            tag2_owner_r;
  logic [XLEN-1:0] alu_op1_r;
  logic [XLEN-1:0] alu_op2_r;
  logic [3:0]      alu_exec_type_r;
  logic [4:0]      alu_rd_r;
  logic [1:0]      rsp_valid_r;
  logic [1:0]      rsp_rd_en_r;
  logic [4:0]      rsp_rd_r     [2];
  logic [XLEN-1:0] rsp_rd_reg_r [2];

  // Eligibility, response handshakes and result-capture strobes
  always_comb begin
    elig_s      = {bus.i_req1_valid & ~busy_r[1], bus.i_req0_valid & ~busy_r[0]};
    rsp_ready_s = {bus.i_rsp1_ready, bus.i_rsp0_ready};
    rsp_hs_s    = rsp_valid_r & rsp_ready_s;
    cap_s       = {tag2_valid_r & tag2_owner_r, tag2_valid_r & ~tag2_owner_r};
  end

`ifdef NNRV_ALU_ARB_FIXED_PRI_EN
  // Grant: requester 0 always wins a tie; ready never looks at its own valid
  always_comb begin
    ready_s = 2'b00;
    if (i_rst_n) begin
      ready_s[0] = ~busy_r[0];
      ready_s[1] = ~busy_r[1] & ~elig_s[0];
    end else begin
      ready_s = 2'b00;
    end
  end
`else
  logic prio_r;  // 1: requester 1 is preferred on the next tie

  // Round-robin pointer, moves only when something is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio_r <= 1'b0;
    end else if (acc_s[0]) begin
      prio_r <= 1'b1;
    end else if (acc_s[1]) begin
      prio_r <= 1'b0;
    end
  end

  // Grant: pointer breaks ties; ready never looks at its own valid
  always_comb begin
    ready_s = 2'b00;
    if (i_rst_n) begin
      ready_s[0] = ~busy_r[0] & (~elig_s[1] | ~prio_r);
      ready_s[1] = ~busy_r[1] & (~elig_s[0] | prio_r);
    end else begin
      ready_s = 2'b00;
    end
  end
`endif

  assign acc_s = ready_s & {bus.i_req1_valid, bus.i_req0_valid};

  // Outstanding-operation flags: set on accept, cleared on response handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_r <= 2'b00;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (acc_s[n]) begin
          busy_r[n] <= 1'b1;
        end else if (rsp_hs_s[n]) begin
          busy_r[n] <= 1'b0;
        end
      end
    end
  end

  // ALU issue stage; idle cycles drive exec_type 0 and hold the other fields
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_op1_r       <= {XLEN{1'b0}};
      alu_op2_r       <= {XLEN{1'b0}};
      alu_exec_type_r <= 4'd0;
      alu_rd_r        <= 5'd0;
      tag1_valid_r    <= 1'b0;
      tag1_owner_r    <= 1'b0;
    end else if (acc_s[0]) begin
      alu_op1_r       <= bus.i_req0_op1;
      alu_op2_r       <= bus.i_req0_op2;
      alu_exec_type_r <= bus.i_req0_exec_type;
      alu_rd_r        <= bus.i_req0_rd;
      tag1_valid_r    <= 1'b1;
      tag1_owner_r    <= 1'b0;
    end else if (acc_s[1]) begin
      alu_op1_r       <= bus.i_req1_op1;
      alu_op2_r       <= bus.i_req1_op2;
      alu_exec_type_r <= bus.i_req1_exec_type;
      alu_rd_r        <= bus.i_req1_rd;
      tag1_valid_r    <= 1'b1;
      tag1_owner_r    <= 1'b1;
    end else begin
      alu_exec_type_r <= 4'd0;
      tag1_valid_r    <= 1'b0;
    end
  end

  // Owner tag delayed one more stage to line up with the ALU's registered result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag2_valid_r <= 1'b0;
      tag2_owner_r <= 1'b0;
    end else begin
      tag2_valid_r <= tag1_valid_r;
      tag2_owner_r <= tag1_owner_r;
    end
  end

  // Per-requester response buffers; untagged ALU results are ignored
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_r <= 2'b00;
      rsp_rd_en_r <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        rsp_rd_r[n]     <= 5'd0;
        rsp_rd_reg_r[n] <= {XLEN{1'b0}};
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (cap_s[n]) begin
          rsp_valid_r[n]  <= 1'b1;
          rsp_rd_en_r[n]  <= bus.i_alu_rd_en;
          rsp_rd_r[n]     <= bus.i_alu_rd;
          rsp_rd_reg_r[n] <= bus.i_alu_rd_reg;
        end else if (rsp_hs_s[n]) begin
          rsp_valid_r[n]  <= 1'b0;
          rsp_rd_en_r[n]  <= 1'b0;
          rsp_rd_r[n]     <= 5'd0;
          rsp_rd_reg_r[n] <= {XLEN{1'b0}};
        end
      end
    end
  end

  assign bus.o_req0_ready    = ready_s[0];
  assign bus.o_req1_ready    = ready_s[1];
  assign bus.o_alu_op1       = alu_op1_r;
  assign bus.o_alu_op2       = alu_op2_r;
  assign bus.o_alu_exec_type = alu_exec_type_r;
  assign bus.o_alu_rd        = alu_rd_r;
  assign bus.o_rsp0_valid    = rsp_valid_r[0];
  assign bus.o_rsp0_rd_en    = rsp_rd_en_r[0];
  assign bus.o_rsp0_rd       = rsp_rd_r[0];
  assign bus.o_rsp0_rd_reg   = rsp_rd_reg_r[0];
  assign bus.o_rsp1_valid    = rsp_valid_r[1];
  assign bus.o_rsp1_rd_en    = rsp_rd_en_r[1];
  assign bus.o_rsp1_rd       = rsp_rd_r[1];
  assign bus.o_rsp1_rd_reg   = rsp_rd_reg_r[1];
endmodule

// File: tb/tb_nnrv_alu_arb.sv
// Directed bench for nnrv_alu_arb with a small registered ADD/SUB ALU model.
// Expected arbitration order follows NNRV_ALU_ARB_FIXED_PRI_EN when it is defined.
module tb_nnrv_alu_arb;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  nnrv_alu_arb_if #(.XLEN(XLEN)) bus ();

  nnrv_alu_arb #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: result registered one cycle after its inputs, never reset
  always @(posedge clk) begin
    bus.i_alu_rd_en <= (bus.o_alu_exec_type != 4'd0);
    bus.i_alu_rd    <= bus.o_alu_rd;
    case (bus.o_alu_exec_type)
      4'd1:    bus.i_alu_rd_reg <= bus.o_alu_op1 + bus.o_alu_op2;
      4'd2:    bus.i_alu_rd_reg <= bus.o_alu_op1 - bus.o_alu_op2;
      default: bus.i_alu_rd_reg <= {XLEN{1'b0}};
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef NNRV_ALU_ARB_FIXED_PRI_EN
  logic [1:0] exp_rdy [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
`else
  logic [1:0] exp_rdy [6] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01};
`endif

  initial begin
    rst_n                = 1'b0;
    bus.i_req0_valid     = 1'b0;
    bus.i_req0_op1       = 32'd0;
    bus.i_req0_op2       = 32'd0;
    bus.i_req0_exec_type = 4'd0;
    bus.i_req0_rd        = 5'd0;
    bus.i_req1_valid     = 1'b0;
    bus.i_req1_op1       = 32'd0;
    bus.i_req1_op2       = 32'd0;
    bus.i_req1_exec_type = 4'd0;
    bus.i_req1_rd        = 5'd0;
    bus.i_rsp0_ready     = 1'b0;
    bus.i_rsp1_ready     = 1'b0;
    #12;

    // Reset values
    check("rst_ready", {bus.o_req1_ready, bus.o_req0_ready}, 64'd0);
    check("rst_rsp_valid", {bus.o_rsp1_valid, bus.o_rsp0_valid}, 64'd0);
    check("rst_rsp0_fields", {bus.o_rsp0_rd_en, bus.o_rsp0_rd, bus.o_rsp0_rd_reg}, 64'd0);
    check("rst_alu_type", bus.o_alu_exec_type, 64'd0);
    check("rst_alu_ops", {bus.o_alu_op1, bus.o_alu_op2}, 64'd0);
    check("rst_alu_rd", bus.o_alu_rd, 64'd0);
    step();
    rst_n = 1'b1;

    // Single ADD from requester 0, accepted on the first edge after reset
    bus.i_req0_valid     = 1'b1;
    bus.i_req0_op1       = 32'd1;
    bus.i_req0_op2       = 32'd2;
    bus.i_req0_exec_type = 4'd1;
    bus.i_req0_rd        = 5'd5;
    bus.i_rsp0_ready     = 1'b1;
    #1;
    check("t1_ready0", bus.o_req0_ready, 64'd1);
    step();
    bus.i_req0_valid = 1'b0;
    check("t1_alu_type", bus.o_alu_exec_type, 64'd1);
    check("t1_alu_ops", {bus.o_alu_op1, bus.o_alu_op2}, {32'd1, 32'd2});
    check("t1_alu_rd", bus.o_alu_rd, 64'd5);
    check("t1_busy_ready0", bus.o_req0_ready, 64'd0);
    step();
    check("t1_alu_idle", bus.o_alu_exec_type, 64'd0);
    check("t1_alu_op1_held", bus.o_alu_op1, 64'd1);
    check("t1_rsp0_early", bus.o_rsp0_valid, 64'd0);
    step();
    check("t1_rsp0_valid", bus.o_rsp0_valid, 64'd1);
    check("t1_rsp0_fields", {bus.o_rsp0_rd_en, bus.o_rsp0_rd, bus.o_rsp0_rd_reg}, {1'b1, 5'd5, 32'd3});
    step();
    check("t1_rsp0_done", bus.o_rsp0_valid, 64'd0);
    check("t1_ready0_again", bus.o_req0_ready, 64'd1);

    // Both requesters continuously valid with SUB
    bus.i_req0_valid     = 1'b1;
    bus.i_req0_op1       = 32'd10;
    bus.i_req0_op2       = 32'd3;
    bus.i_req0_exec_type = 4'd2;
    bus.i_req0_rd        = 5'd7;
    bus.i_req1_valid     = 1'b1;
    bus.i_req1_op1       = 32'd100;
    bus.i_req1_op2       = 32'd1;
    bus.i_req1_exec_type = 4'd2;
    bus.i_req1_rd        = 5'd9;
    bus.i_rsp1_ready     = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_ready_k%0d", k), {bus.o_req1_ready, bus.o_req0_ready}, exp_rdy[k]);
      if (k == 1 || k == 2) check($sformatf("t2_alu_type_k%0d", k), bus.o_alu_exec_type, 64'd2);
      if (k == 3) check("t2_alu_idle", bus.o_alu_exec_type, 64'd0);
`ifdef NNRV_ALU_ARB_FIXED_PRI_EN
      if (k == 1) check("t2_alu_op1_first", bus.o_alu_op1, 64'd10);
      if (k == 2) check("t2_alu_op1_second", bus.o_alu_op1, 64'd100);
      if (k == 3) check("t2_rsp_first", {bus.o_rsp1_valid, bus.o_rsp0_valid, bus.o_rsp0_rd, bus.o_rsp0_rd_reg}, {2'b01, 5'd7, 32'd7});
      if (k == 4) check("t2_rsp_second", {bus.o_rsp1_valid, bus.o_rsp0_valid, bus.o_rsp1_rd, bus.o_rsp1_rd_reg}, {2'b10, 5'd9, 32'd99});
`else
      if (k == 1) check("t2_alu_op1_first", bus.o_alu_op1, 64'd100);
      if (k == 2) check("t2_alu_op1_second", bus.o_alu_op1, 64'd10);
      if (k == 3) check("t2_rsp_first", {bus.o_rsp1_valid, bus.o_rsp0_valid, bus.o_rsp1_rd, bus.o_rsp1_rd_reg}, {2'b10, 5'd9, 32'd99});
      if (k == 4) check("t2_rsp_second", {bus.o_rsp1_valid, bus.o_rsp0_valid, bus.o_rsp0_rd, bus.o_rsp0_rd_reg}, {2'b01, 5'd7, 32'd7});
`endif
      step();
    end
    bus.i_req0_valid = 1'b0;
    bus.i_req1_valid = 1'b0;
    repeat (5) step();
    check("t2_drained_rsp", {bus.o_rsp1_valid, bus.o_rsp0_valid}, 64'd0);
    check("t2_drained_ready", {bus.o_req1_ready, bus.o_req0_ready}, 64'd3);

    // Requester 1 response back-pressured while requester 0 keeps working
    bus.i_rsp1_ready     = 1'b0;
    bus.i_req1_valid     = 1'b1;
    bus.i_req1_op1       = 32'd20;
    bus.i_req1_op2       = 32'd22;
    bus.i_req1_exec_type = 4'd1;
    bus.i_req1_rd        = 5'd3;
    #1;
    check("t3_ready1", bus.o_req1_ready, 64'd1);
    step();
    bus.i_req1_valid = 1'b0;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        bus.i_req0_valid     = 1'b1;
        bus.i_req0_op1       = 32'd5;
        bus.i_req0_op2       = 32'd6;
        bus.i_req0_exec_type = 4'd1;
        bus.i_req0_rd        = 5'd4;
        #1;
        check("t3_ready0", bus.o_req0_ready, 64'd1);
      end
      if (i == 1) begin
        bus.i_req0_valid = 1'b0;
        check("t3_alu_req0", {bus.o_alu_exec_type, bus.o_alu_rd}, {4'd1, 5'd4});
      end
      if (i == 3) check("t3_rsp0", {bus.o_rsp0_valid, bus.o_rsp0_rd_reg}, {1'b1, 32'd11});
      check($sformatf("t3_rsp1_hold_i%0d", i), {bus.o_rsp1_valid, bus.o_rsp1_rd_en, bus.o_rsp1_rd, bus.o_rsp1_rd_reg}, {1'b1, 1'b1, 5'd3, 32'd42});
      check($sformatf("t3_ready1_low_i%0d", i), bus.o_req1_ready, 64'd0);
      step();
    end
    bus.i_rsp1_ready = 1'b1;
    step();
    check("t3_rsp1_done", bus.o_rsp1_valid, 64'd0);
    check("t3_ready1_again", bus.o_req1_ready, 64'd1);

    // exec_type 0 still produces a response, with rd_en low
    bus.i_req0_valid     = 1'b1;
    bus.i_req0_op1       = 32'd7;
    bus.i_req0_op2       = 32'd8;
    bus.i_req0_exec_type = 4'd0;
    bus.i_req0_rd        = 5'd6;
    #1;
    check("t4_ready0", bus.o_req0_ready, 64'd1);
    step();
    bus.i_req0_valid = 1'b0;
    check("t4_busy", bus.o_req0_ready, 64'd0);
    step();
    step();
    check("t4_rsp0", {bus.o_rsp0_valid, bus.o_rsp0_rd_en, bus.o_rsp0_rd, bus.o_rsp0_rd_reg}, {1'b1, 1'b0, 5'd6, 32'd0});
    step();
    check("t4_rsp0_done", bus.o_rsp0_valid, 64'd0);

    // Reset one cycle after accept drops the in-flight operation
    bus.i_req1_valid     = 1'b1;
    bus.i_req1_op1       = 32'd1;
    bus.i_req1_op2       = 32'd1;
    bus.i_req1_exec_type = 4'd1;
    bus.i_req1_rd        = 5'd2;
    #1;
    check("t5_ready1", bus.o_req1_ready, 64'd1);
    step();
    bus.i_req1_valid = 1'b0;
    check("t5_alu_type", bus.o_alu_exec_type, 64'd1);
    step();
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", {bus.o_req1_ready, bus.o_req0_ready}, 64'd0);
    check("t5_rst_rsp", {bus.o_rsp1_valid, bus.o_rsp0_valid, bus.o_rsp1_rd_en, bus.o_rsp1_rd, bus.o_rsp1_rd_reg}, 64'd0);
    check("t5_rst_alu", {bus.o_alu_exec_type, bus.o_alu_rd, bus.o_alu_op1}, 64'd0);
    check("t5_rst_alu_op2", bus.o_alu_op2, 64'd0);
    #2;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      check($sformatf("t5_no_rsp_j%0d", j), bus.o_rsp1_valid, 64'd0);
      check($sformatf("t5_ready1_j%0d", j), bus.o_req1_ready, 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
